// File: rtl/pixie_pkg.sv
// Shared encodings for the Pixie DMA responder: SC codes, FSM states and the
// default address width.
package pixie_pkg;

  localparam int ADDR_W_DEF = 16;

  localparam logic [1:0] SC_FETCH = 2'b00;
  localparam logic [1:0] SC_EXEC  = 2'b01;
  localparam logic [1:0] SC_DMA   = 2'b10;
  localparam logic [1:0] SC_INT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DMA_RD,
    ST_DMA_XFER,
    ST_INT_ACK
  } state_t;

endpackage

// File: rtl/pixie_r0_reg.sv
// R0 (DMA pointer) register. The increment takes priority over a load and
// wraps from all-ones to zero.
module pixie_r0_reg #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (inc)  q <= q + ADDR_W'(1);
    else if (load) q <= wdata;
  end

endmodule

// File: rtl/pixie_dma_responder.sv
// CDP1802-style DMA-out (S2) and interrupt-acknowledge (S3) responder for the
// Pixie display. Optional byte statistics are enabled with PIXIE_DMA_STATS_EN.
module pixie_dma_responder
  import pixie_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              cycle_boundary,
  input  logic              ie,
  input  logic              DMAO,
  input  logic              INT,
  input  logic              r0_load,
  input  logic [ADDR_W-1:0] r0_wdata,
  output logic [ADDR_W-1:0] r0_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [7:0]        dma_data,
  output logic              dma_strobe,
  output logic [1:0]        SC,
  output logic              cpu_hold,
  output logic              int_ack,
  output state_t            state_dbg
`ifdef PIXIE_DMA_STATS_EN
  ,
  output logic [15:0]       dma_count,
  output logic [15:0]       last_frame_count
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);

  state_t        state, state_next;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_next;
  logic          burst_more;

  assign state_dbg  = state;
  assign burst_next = burst_cnt + BW'(1);
  assign burst_more = (burst_next < BW'(MAX_BURST));

  pixie_r0_reg #(.ADDR_W(ADDR_W)) u_r0 (
    .clk   (clk),
    .reset (reset),
    .load  (r0_load && (state == ST_IDLE)),
    .inc   (clk_enable && (state == ST_DMA_XFER)),
    .wdata (r0_wdata),
    .q     (r0_q)
  );

  // Bus outputs are decoded from the registered state only, so they hold
  // whenever clk_enable is low.
  always_comb begin
    state_next = state;
    SC         = SC_FETCH;
    cpu_hold   = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    case (state)
      ST_IDLE: begin
        if (cycle_boundary) begin
          if (DMAO)            state_next = ST_DMA_RD;
          else if (INT && ie)  state_next = ST_INT_ACK;
        end
      end
      ST_DMA_RD: begin
        SC         = SC_DMA;
        cpu_hold   = 1'b1;
        mem_rd     = 1'b1;
        mem_addr   = r0_q;
        state_next = ST_DMA_XFER;
      end
      ST_DMA_XFER: begin
        SC         = SC_DMA;
        cpu_hold   = 1'b1;
        state_next = (DMAO && burst_more) ? ST_DMA_RD : ST_IDLE;
      end
      ST_INT_ACK: begin
        SC         = SC_INT;
        cpu_hold   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // dma_strobe and int_ack are single-clock pulses launched on the enabled
  // edge that leaves DMA_XFER / INT_ACK; the display takes dma_data exactly
  // in the clock where dma_strobe is high, with no back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      burst_cnt  <= '0;
      dma_data   <= 8'h00;
      dma_strobe <= 1'b0;
      int_ack    <= 1'b0;
    end else begin
      dma_strobe <= 1'b0;
      int_ack    <= 1'b0;
      if (clk_enable) begin
        state <= state_next;
        if (state == ST_DMA_XFER) begin
          dma_data   <= mem_data;
          dma_strobe <= 1'b1;
          burst_cnt  <= (state_next == ST_DMA_RD) ? burst_next : '0;
        end
        if (state == ST_INT_ACK) int_ack <= 1'b1;
      end
    end
  end

`ifdef PIXIE_DMA_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_count        <= 16'h0000;
      last_frame_count <= 16'h0000;
    end else if (clk_enable) begin
      if ((state == ST_DMA_XFER) && (dma_count != 16'hFFFF))
        dma_count <= dma_count + 16'h0001;
      if (state == ST_INT_ACK) begin
        last_frame_count <= dma_count;
        dma_count        <= 16'h0000;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixie_dma_responder.sv
// Scoreboard bench for pixie_dma_responder: expected bytes, read addresses and
// acknowledges are queued by the drivers and consumed by a negedge monitor.
module tb_pixie_dma_responder;
  import pixie_pkg::*;

  localparam int ADDR_W    = 16;
  localparam int MAX_BURST = 8;

  logic              clk;
  logic              reset;
  logic              clk_enable;
  logic              cycle_boundary;
  logic              ie;
  logic              DMAO;
  logic              INT;
  logic              r0_load;
  logic [ADDR_W-1:0] r0_wdata;
  logic [ADDR_W-1:0] r0_q;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic [7:0]        dma_data;
  logic              dma_strobe;
  logic [1:0]        SC;
  logic              cpu_hold;
  logic              int_ack;
  state_t            state_dbg;
`ifdef PIXIE_DMA_STATS_EN
  logic [15:0]       dma_count;
  logic [15:0]       last_frame_count;
`endif

  pixie_dma_responder #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .cycle_boundary (cycle_boundary),
    .ie             (ie),
    .DMAO           (DMAO),
    .INT            (INT),
    .r0_load        (r0_load),
    .r0_wdata       (r0_wdata),
    .r0_q           (r0_q),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .dma_data       (dma_data),
    .dma_strobe     (dma_strobe),
    .SC             (SC),
    .cpu_hold       (cpu_hold),
    .int_ack        (int_ack),
    .state_dbg      (state_dbg)
`ifdef PIXIE_DMA_STATS_EN
    ,
    .dma_count        (dma_count),
    .last_frame_count (last_frame_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- memory model ----------------
  logic [7:0] mem [0:65535];
  always @(posedge clk) if (clk_enable && mem_rd) mem_data <= mem[mem_addr];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic              exp_ack_q[$];
  logic [ADDR_W-1:0] model_r0;
  int                stats_bytes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dma_strobe) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dma_strobe: got byte %0h expected no strobe", dma_data);
      end else check("dma_data", dma_data, exp_q.pop_front());
    end
    if (mem_rd && clk_enable) begin
      if (exp_addr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL mem_rd: got read at %0h expected no read", mem_addr);
      end else check("mem_addr", mem_addr, exp_addr_q.pop_front());
    end
    if (int_ack) begin
      if (exp_ack_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL int_ack: got pulse expected none");
      end else check("int_ack", int_ack, exp_ack_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_enable = 1'($urandom_range(1));
    tick();
    tick();
    reset = 1'b0;
    model_r0 = '0;
    stats_bytes = 0;
  endtask

  task automatic load_r0(input logic [ADDR_W-1:0] v);
    r0_load    = 1'b1;
    r0_wdata   = v;
    clk_enable = 1'($urandom_range(1));
    tick();
    r0_load    = 1'b0;
    model_r0   = v;
  endtask

  task automatic settle(input int k);
    clk_enable = 1'b1;
    DMAO = 1'b0;
    repeat (k) tick();
  endtask

  // Runs n bytes with DMAO held until the final byte's transfer cycle; bursts
  // split every MAX_BURST bytes, each costing one accept plus two cycles/byte.
  task automatic run_dma(input int n, input bit junk_load, output int idle_cycles);
    int total = 0;
    int edges = 0;
    int left  = n;
    int guard = 0;
    while (left > 0) begin
      int b = (left > MAX_BURST) ? MAX_BURST : left;
      total += 1 + 2 * b;
      left  -= b;
    end
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(model_r0);
      exp_q.push_back(mem[model_r0]);
      model_r0 = model_r0 + 16'd1;
      stats_bytes++;
    end
    idle_cycles    = 0;
    cycle_boundary = 1'b1;
    while (edges < total && guard < 4000) begin
      guard++;
      clk_enable = ($urandom_range(3) != 0);
      DMAO       = (edges < total - 1);
      r0_load    = junk_load && (edges >= 1);
      r0_wdata   = 16'($urandom);
      @(negedge clk);
      if (edges >= 1 && !cpu_hold) idle_cycles++;
      @(posedge clk);
      #1;
      if (clk_enable) edges++;
    end
    if (guard >= 4000) begin
      n_cmp++; n_bad++;
      $display("FAIL run_dma_budget: got %0d enabled edges expected %0d", edges, total);
    end
    DMAO    = 1'b0;
    r0_load = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_r0"}, r0_q, model_r0);
    check({name, "_sc"}, SC, SC_FETCH);
`ifdef PIXIE_DMA_STATS_EN
    check({name, "_dma_count"}, dma_count, stats_bytes);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idle;
    reset = 1'b1; clk_enable = 1'b0; cycle_boundary = 1'b0; ie = 1'b0;
    DMAO = 1'b0; INT = 1'b0; r0_load = 1'b0; r0_wdata = '0; mem_data = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem[16'h1000 + i] = 8'(i);

    // reset state
    do_reset();
    check("rst_r0", r0_q, 0);
    check("rst_sc", SC, SC_FETCH);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_dma_data", dma_data, 0);
    check("rst_strobe", dma_strobe, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_int_ack", int_ack, 0);

    // 8-byte burst from 0x1000 with CPU load attempts dropped while held
    load_r0(16'h1000);
    check("load_r0", r0_q, 16'h1000);
    run_dma(8, 1'b1, idle);
    check("burst_no_gap", idle, 0);
    settle(3);
    check_idle("t1");

    // continuous DMAO: the CPU regains a slot after MAX_BURST bytes
    load_r0(16'h1200);
    run_dma(16, 1'b0, idle);
    check("burst_gap_seen", (idle >= 1), 1);
    settle(3);
    check_idle("t2");

    // DMA wins over a simultaneous enabled interrupt
    INT = 1'b1; ie = 1'b1;
    run_dma(3, 1'b0, idle);
    clk_enable = 1'b1;
    exp_ack_q.push_back(1'b1);
    tick();
    INT = 1'b0;
    check("t3_sc_int", SC, SC_INT);
    check("t3_hold", cpu_hold, 1);
    tick();
    tick();
`ifdef PIXIE_DMA_STATS_EN
    check("t3_last_frame", last_frame_count, stats_bytes);
    stats_bytes = 0;
`endif
    check_idle("t3");

    // INT pending while ie=0, then off-boundary and disabled cycles
    INT = 1'b1; ie = 1'b0; cycle_boundary = 1'b1;
    repeat (10) begin clk_enable = 1'($urandom_range(1)); tick(); end
    check("t4_ie0_sc", SC, SC_FETCH);
    ie = 1'b1; cycle_boundary = 1'b0; clk_enable = 1'b1;
    repeat (5) tick();
    check("t4_noboundary_sc", SC, SC_FETCH);
    cycle_boundary = 1'b1; clk_enable = 1'b0;
    repeat (2) tick();
    check("t4_disabled_sc", SC, SC_FETCH);
    clk_enable = 1'b1;
    exp_ack_q.push_back(1'b1);
    tick();
    INT = 1'b0;
    check("t4_sc_int", SC, SC_INT);
    check("t4_r0_kept", r0_q, model_r0);
    tick();
    tick();
    stats_bytes = 0;
    ie = 1'b0;

    // R0 wrap
    load_r0(16'hFFFF);
    run_dma(1, 1'b0, idle);
    settle(3);
    check_idle("t5");

    // reset in the middle of a transfer
    load_r0(16'h2000);
    cycle_boundary = 1'b1; clk_enable = 1'b1; DMAO = 1'b1;
    exp_addr_q.push_back(16'h2000);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t6_rst_strobe", dma_strobe, 0);
    check("t6_rst_sc", SC, SC_FETCH);
    check("t6_rst_r0", r0_q, 0);
    check("t6_rst_hold", cpu_hold, 0);
    reset = 1'b0; DMAO = 1'b0; model_r0 = '0; stats_bytes = 0;
    tick();

    // clk_enable stretching; DMAO drops during the read and the byte completes
    load_r0(16'h3000);
    exp_addr_q.push_back(16'h3000);
    exp_q.push_back(mem[16'h3000]);
    model_r0 = 16'h3001;
    stats_bytes++;
    DMAO = 1'b1; clk_enable = 1'b1;
    tick();
    DMAO = 1'b0; clk_enable = 1'b0;
    for (int i = 0; i < 4; i++) check("t6_stretch_sc", SC, SC_DMA);
    repeat (4) tick();
    check("t6_stretch_rd", mem_rd, 1);
    clk_enable = 1'b1;
    tick();
    clk_enable = 1'b0;
    tick();
    check("t6_xfer_hold_strobe", dma_strobe, 0);
    check("t6_xfer_hold_sc", SC, SC_DMA);
    clk_enable = 1'b1;
    tick();
    check("t6_strobe_on", dma_strobe, 1);
    clk_enable = 1'b0;
    tick();
    check("t6_strobe_pulse", dma_strobe, 0);
    settle(2);
    check_idle("t6");

    // randomized bursts
    for (int k = 0; k < 6; k++) begin
      load_r0(16'($urandom));
      run_dma($urandom_range(1, 12), 1'b0, idle);
      settle(3);
      check_idle("rand");
    end

    settle(4);
    check("exp_q_empty", exp_q.size(), 0);
    check("exp_addr_q_empty", exp_addr_q.size(), 0);
    check("exp_ack_q_empty", exp_ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
